// File: rtl/seq_controller_pkg.sv
// Shared constants for the byte-sequence controller: widths, FSM states and
// the 8-entry sequence byte table used by the mapping block.
package seq_controller_pkg;

   localparam int SEQ_W = 3;
   localparam int LEN_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [7:0] SEQ_BYTE_0 = 8'hAF;
   localparam logic [7:0] SEQ_BYTE_1 = 8'hBC;
   localparam logic [7:0] SEQ_BYTE_2 = 8'hE2;
   localparam logic [7:0] SEQ_BYTE_3 = 8'h78;
   localparam logic [7:0] SEQ_BYTE_4 = 8'hFF;
   localparam logic [7:0] SEQ_BYTE_5 = 8'hE2;
   localparam logic [7:0] SEQ_BYTE_6 = 8'h0B;
   localparam logic [7:0] SEQ_BYTE_7 = 8'h8D;

   function automatic logic [7:0] seqByte(input logic [SEQ_W-1:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = SEQ_BYTE_0;
         3'd1:    b = SEQ_BYTE_1;
         3'd2:    b = SEQ_BYTE_2;
         3'd3:    b = SEQ_BYTE_3;
         3'd4:    b = SEQ_BYTE_4;
         3'd5:    b = SEQ_BYTE_5;
         3'd6:    b = SEQ_BYTE_6;
         default: b = SEQ_BYTE_7;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/seq_controller_output_logic.sv
// Combinational index-to-byte mapping for the sequence table.
module output_logic
   import seq_controller_pkg::*;
(
   input  logic [SEQ_W-1:0] i_index,
   output logic [7:0]       o_data
);

   assign o_data = seqByte(i_index);

endmodule

// File: rtl/seq_controller.sv
// Burst sequencer: walks the index counter from a start point and presents
// the mapped bytes downstream over a valid/ready handshake.
module seq_controller
   import seq_controller_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             stop,
   input  logic [SEQ_W-1:0] start_idx,
   input  logic [LEN_W-1:0] burst_len,
   input  logic             ready,
   output logic             valid,
   output logic [7:0]       data_out,
   output logic [SEQ_W-1:0] counter,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [LEN_W-1:0] beat_cnt
);

   state_t           r_state;
   logic [SEQ_W-1:0] r_counter;
   logic [LEN_W-1:0] r_remaining;
   logic [LEN_W-1:0] r_beatCnt;
   logic             r_valid;
   logic             r_busy;
   logic             r_done;
   logic             r_aborted;
   logic             w_xfer;
   logic             w_lastBeat;

   assign w_xfer     = r_valid && ready;
   assign w_lastBeat = (r_remaining == LEN_W'(1));

   // remaining==0 marks continuous mode; a finishing beat beats a same-cycle stop.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_counter   <= '0;
         r_remaining <= '0;
         r_beatCnt   <= '0;
         r_valid     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_aborted   <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start && !stop) begin
                  r_state     <= RUN;
                  r_counter   <= start_idx;
                  r_remaining <= burst_len;
                  r_beatCnt   <= '0;
                  r_valid     <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end
            RUN: begin
               if (w_xfer) begin
                  r_counter <= r_counter + SEQ_W'(1);
                  if (r_beatCnt != '1)
                     r_beatCnt <= r_beatCnt + LEN_W'(1);
                  if (w_lastBeat) begin
                     r_state <= IDLE;
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     if (r_remaining != '0)
                        r_remaining <= r_remaining - LEN_W'(1);
                     if (stop) begin
                        r_state   <= IDLE;
                        r_valid   <= 1'b0;
                        r_busy    <= 1'b0;
                        r_aborted <= 1'b1;
                     end
                  end
               end else if (stop) begin
                  r_state   <= IDLE;
                  r_valid   <= 1'b0;
                  r_busy    <= 1'b0;
                  r_aborted <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   output_logic u_outputLogic (
      .i_index (r_counter),
      .o_data  (data_out)
   );

   assign valid    = r_valid;
   assign busy     = r_busy;
   assign done     = r_done;
   assign aborted  = r_aborted;
   assign counter  = r_counter;
   assign beat_cnt = r_beatCnt;

endmodule

// File: tb/tb_seq_controller.sv
// Self-checking bench for seq_controller: table-driven cycle vectors plus
// hand-written corner sequences, with a byte scoreboard checked on transfers.
module tb_seq_controller;
   import seq_controller_pkg::*;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             start;
   logic             stop;
   logic [SEQ_W-1:0] start_idx;
   logic [LEN_W-1:0] burst_len;
   logic             ready;
   logic             valid;
   logic [7:0]       data_out;
   logic [SEQ_W-1:0] counter;
   logic             busy;
   logic             done;
   logic             aborted;
   logic [LEN_W-1:0] beat_cnt;

   int compared   = 0;
   int mismatched = 0;
   int xferCount  = 0;

   logic [7:0] expQ [$];
   logic [7:0] refTable [8];

   typedef struct {
      logic       start;
      logic       stop;
      logic [2:0] idx;
      logic [7:0] len;
      logic       rdy;
      logic       expValid;
      logic [2:0] expCounter;
      logic       expDone;
      logic       expAborted;
      logic [7:0] expBeat;
   } vec_t;

   vec_t vecs [10];

   seq_controller dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .stop      (stop),
      .start_idx (start_idx),
      .burst_len (burst_len),
      .ready     (ready),
      .valid     (valid),
      .data_out  (data_out),
      .counter   (counter),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted),
      .beat_cnt  (beat_cnt)
   );

   always #5 clk = ~clk;

   function automatic vec_t mkVec(input int st, input int sp, input int idx, input int len,
                                  input int rdy, input int v, input int c, input int d,
                                  input int a, input int b);
      vec_t m;
      m.start      = st[0];
      m.stop       = sp[0];
      m.idx        = idx[2:0];
      m.len        = len[7:0];
      m.rdy        = rdy[0];
      m.expValid   = v[0];
      m.expCounter = c[2:0];
      m.expDone    = d[0];
      m.expAborted = a[0];
      m.expBeat    = b[7:0];
      return m;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic st, input logic sp, input int idx, input int len,
                                input logic rdy);
      start     = st;
      stop      = sp;
      start_idx = idx[2:0];
      burst_len = len[7:0];
      ready     = rdy;
   endtask

   task automatic pushBurst(input int idx, input int n);
      for (int i = 0; i < n; i++)
         expQ.push_back(refTable[(idx + i) % 8]);
   endtask

   // Every accepted beat is matched against the next expected byte.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
         xferCount++;
         if (expQ.size() == 0) begin
            checkOutput("unexpected_beat", {24'd0, data_out}, 32'hFFFF_FFFF);
         end else begin
            logic [7:0] e;
            e = expQ.pop_front();
            checkOutput("data_out", {24'd0, data_out}, {24'd0, e});
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int x0;
      refTable[0] = 8'hAF; refTable[1] = 8'hBC; refTable[2] = 8'hE2; refTable[3] = 8'h78;
      refTable[4] = 8'hFF; refTable[5] = 8'hE2; refTable[6] = 8'h0B; refTable[7] = 8'h8D;

      //               st sp idx len rdy  v  cnt d  a  beat
      vecs[0] = mkVec(1, 0, 0, 3, 1,   1, 0, 0, 0, 0);
      vecs[1] = mkVec(0, 0, 0, 0, 1,   1, 1, 0, 0, 1);
      vecs[2] = mkVec(0, 0, 0, 0, 1,   1, 2, 0, 0, 2);
      vecs[3] = mkVec(0, 0, 0, 0, 1,   0, 3, 1, 0, 3);
      vecs[4] = mkVec(1, 0, 6, 4, 1,   1, 6, 0, 0, 0);
      vecs[5] = mkVec(0, 0, 0, 0, 1,   1, 7, 0, 0, 1);
      vecs[6] = mkVec(0, 0, 0, 0, 1,   1, 0, 0, 0, 2);
      vecs[7] = mkVec(0, 0, 0, 0, 1,   1, 1, 0, 0, 3);
      vecs[8] = mkVec(0, 0, 0, 0, 1,   0, 2, 1, 0, 4);
      vecs[9] = mkVec(0, 0, 0, 0, 1,   0, 2, 0, 0, 4);

      reset_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
      tick();
      tick();
      checkOutput("rst_valid", {31'd0, valid}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_counter", {29'd0, counter}, 32'd0);
      checkOutput("rst_beat", {24'd0, beat_cnt}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_aborted", {31'd0, aborted}, 32'd0);
      checkOutput("rst_data", {24'd0, data_out}, 32'hAF);
      reset_n = 1'b1;
      tick();

      // Two finite bursts, the second started while done is high.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].start, vecs[i].stop, int'(vecs[i].idx), int'(vecs[i].len), vecs[i].rdy);
         if (vecs[i].start && !vecs[i].stop)
            pushBurst(int'(vecs[i].idx), int'(vecs[i].len));
         tick();
         checkOutput($sformatf("vec%0d_valid", i), {31'd0, valid}, {31'd0, vecs[i].expValid});
         checkOutput($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].expValid});
         checkOutput($sformatf("vec%0d_counter", i), {29'd0, counter}, {29'd0, vecs[i].expCounter});
         checkOutput($sformatf("vec%0d_done", i), {31'd0, done}, {31'd0, vecs[i].expDone});
         checkOutput($sformatf("vec%0d_aborted", i), {31'd0, aborted}, {31'd0, vecs[i].expAborted});
         checkOutput($sformatf("vec%0d_beat", i), {24'd0, beat_cnt}, {24'd0, vecs[i].expBeat});
      end
      checkOutput("table_queue_empty", expQ.size(), 32'd0);

      // Backpressure: data must hold through stalls.
      x0 = xferCount;
      applyStimulus(1'b1, 1'b0, 2, 2, 1'b0);
      pushBurst(2, 2);
      tick();
      start = 1'b0;
      ready = 1'b0; tick();
      checkOutput("stall1_data", {24'd0, data_out}, 32'hE2);
      checkOutput("stall1_counter", {29'd0, counter}, 32'd2);
      ready = 1'b0; tick();
      checkOutput("stall2_data", {24'd0, data_out}, 32'hE2);
      ready = 1'b1; tick();
      checkOutput("stall_adv_counter", {29'd0, counter}, 32'd3);
      ready = 1'b0; tick();
      checkOutput("stall3_data", {24'd0, data_out}, 32'h78);
      checkOutput("stall3_valid", {31'd0, valid}, 32'd1);
      ready = 1'b1; tick();
      checkOutput("stall_done", {31'd0, done}, 32'd1);
      checkOutput("stall_xfers", xferCount - x0, 32'd2);
      ready = 1'b0; tick();

      // Continuous mode, then abort with no transfer in the stop cycle.
      applyStimulus(1'b1, 1'b0, 4, 0, 1'b1);
      pushBurst(4, 10);
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done !== 1'b0)
            checkOutput("cont_done_low", {31'd0, done}, 32'd0);
      end
      checkOutput("cont_valid", {31'd0, valid}, 32'd1);
      stop = 1'b1;
      ready = 1'b0;
      tick();
      stop = 1'b0;
      checkOutput("abort_pulse", {31'd0, aborted}, 32'd1);
      checkOutput("abort_done", {31'd0, done}, 32'd0);
      checkOutput("abort_valid", {31'd0, valid}, 32'd0);
      checkOutput("abort_beat", {24'd0, beat_cnt}, 32'd10);
      checkOutput("abort_counter", {29'd0, counter}, 32'd6);
      tick();
      checkOutput("abort_pulse_end", {31'd0, aborted}, 32'd0);
      checkOutput("cont_queue_empty", expQ.size(), 32'd0);

      // Stop on the final beat: completion wins.
      applyStimulus(1'b1, 1'b0, 5, 1, 1'b1);
      pushBurst(5, 1);
      tick();
      start = 1'b0;
      stop = 1'b1;
      tick();
      checkOutput("last_stop_done", {31'd0, done}, 32'd1);
      checkOutput("last_stop_aborted", {31'd0, aborted}, 32'd0);
      checkOutput("last_stop_counter", {29'd0, counter}, 32'd6);
      checkOutput("last_stop_beat", {24'd0, beat_cnt}, 32'd1);

      // Start and stop together in IDLE is ignored.
      applyStimulus(1'b1, 1'b1, 0, 3, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
      checkOutput("ss_valid", {31'd0, valid}, 32'd0);
      checkOutput("ss_busy", {31'd0, busy}, 32'd0);
      tick();
      checkOutput("ss_valid2", {31'd0, valid}, 32'd0);

      // Reset mid-burst after 2 of 5 beats.
      applyStimulus(1'b1, 1'b0, 0, 5, 1'b1);
      pushBurst(0, 2);
      tick();
      start = 1'b0;
      tick();
      tick();
      ready = 1'b0;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      checkOutput("mid_rst_valid", {31'd0, valid}, 32'd0);
      checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("mid_rst_counter", {29'd0, counter}, 32'd0);
      checkOutput("mid_rst_beat", {24'd0, beat_cnt}, 32'd0);
      checkOutput("mid_rst_done", {31'd0, done}, 32'd0);
      checkOutput("mid_rst_aborted", {31'd0, aborted}, 32'd0);
      tick();
      checkOutput("post_rst_done", {31'd0, done}, 32'd0);
      checkOutput("post_rst_aborted", {31'd0, aborted}, 32'd0);
      applyStimulus(1'b1, 1'b0, 3, 2, 1'b1);
      pushBurst(3, 2);
      tick();
      start = 1'b0;
      tick();
      tick();
      checkOutput("post_rst_burst_done", {31'd0, done}, 32'd1);
      checkOutput("post_rst_counter", {29'd0, counter}, 32'd5);
      checkOutput("post_rst_beat", {24'd0, beat_cnt}, 32'd2);
      ready = 1'b0;
      tick();
      checkOutput("final_queue_empty", expQ.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
